// File: rtl/pulse_pkg.sv
// Shared state encodings, display metric codes and default timing
// constants for the pulse session controller.
package pulse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RESTART = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   localparam logic [1:0] SEL_STEPS   = 2'd0;
   localparam logic [1:0] SEL_HIGH    = 2'd1;
   localparam logic [1:0] SEL_MAXRATE = 2'd2;
   localparam logic [1:0] SEL_ELAPSED = 2'd3;

   localparam int CYCLES_PER_SEC_DEF = 100000000;
   localparam int STEP_MAX_DEF       = 9999;
   localparam int HIGH_RATE_DEF      = 32;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/second_ticker.sv
// One-second tick generator: counts enabled CLK cycles and emits a
// single-cycle tick on the last cycle of each second.
module second_ticker
   import pulse_pkg::*;
#(
   parameter int CYCLES_PER_SEC = CYCLES_PER_SEC_DEF
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW =
      (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_SEC - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/pulse_session_ctrl.sv
// Step-counting session controller: runs the pulse generator, gathers
// per-second activity metrics and rotates them onto a display.
module pulse_session_ctrl
   import pulse_pkg::*;
#(
   parameter int CYCLES_PER_SEC = CYCLES_PER_SEC_DEF,
   parameter int STEP_MAX       = STEP_MAX_DEF,
   parameter int HIGH_RATE      = HIGH_RATE_DEF
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START_SW,
   input  logic        MODE_BTN,
   input  logic        PULSE_IN,
   output logic        GEN_START,
   output logic [1:0]  GEN_MODE,
   output logic [1:0]  DISP_SEL,
   output logic [15:0] DISP_VALUE,
   output logic        SAT
);

   localparam int SW = $clog2(STEP_MAX + 1);
   localparam logic [SW-1:0] STEP_TOP = SW'(STEP_MAX);
   localparam logic [8:0]    HR       = 9'(HIGH_RATE);

   state_t state, nxt;

   logic          mode_q, pulse_q;
   logic          press, step_edge;
   logic          run_act, clr_m, tick;
   logic [1:0]    gen_mode;
   logic [1:0]    disp_sel;
   logic [SW-1:0] step_cnt;
   logic [7:0]    sec_cnt, sec_eff;
   logic [7:0]    elapsed, high_secs, max_rate;
   logic [15:0]   disp_mux;

   assign press     = MODE_BTN & ~mode_q;
   assign step_edge = PULSE_IN & ~pulse_q;
   assign run_act   = (state == ST_RUN);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         ST_IDLE:    if (START_SW && !press) nxt = ST_RUN;
         ST_RUN:     if (press) nxt = ST_RESTART;
         ST_RESTART: nxt = ST_RUN;
         default:    nxt = ST_IDLE;
      endcase
      if (!START_SW) nxt = ST_IDLE;
   end

   // Metrics are zero both on a fresh session and throughout RESTART.
   assign clr_m = (state == ST_IDLE && nxt == ST_RUN)
               || (nxt == ST_RESTART)
               || (state == ST_RESTART);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mode_q   <= 1'b0;
         pulse_q  <= 1'b0;
         gen_mode <= 2'd0;
      end else begin
         mode_q  <= MODE_BTN;
         pulse_q <= PULSE_IN;
         if (press) gen_mode <= gen_mode + 2'd1;
      end
   end

   second_ticker #(
      .CYCLES_PER_SEC(CYCLES_PER_SEC)
   ) u_tick (
      .CLK  (CLK),
      .RESET(RESET),
      .clr  (!run_act),
      .en   (run_act),
      .tick (tick)
   );

   // A step landing on the tick belongs to the second that is ending.
   always_comb begin
      sec_eff = sec_cnt;
      if (step_edge) sec_eff = sat_inc8(sec_cnt);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         step_cnt  <= '0;
         sec_cnt   <= 8'd0;
         elapsed   <= 8'd0;
         high_secs <= 8'd0;
         max_rate  <= 8'd0;
         disp_sel  <= 2'd0;
      end else if (clr_m) begin
         step_cnt  <= '0;
         sec_cnt   <= 8'd0;
         elapsed   <= 8'd0;
         high_secs <= 8'd0;
         max_rate  <= 8'd0;
         disp_sel  <= 2'd0;
      end else if (run_act) begin
         if (step_edge && step_cnt != STEP_TOP) begin
            step_cnt <= step_cnt + SW'(1);
         end
         if (tick) begin
            sec_cnt <= 8'd0;
            elapsed <= sat_inc8(elapsed);
            if ({1'b0, sec_eff} > HR) begin
               high_secs <= sat_inc8(high_secs);
            end
            if (sec_eff > max_rate) max_rate <= sec_eff;
            if (elapsed[0]) disp_sel <= disp_sel + 2'd1;
         end else begin
            sec_cnt <= sec_eff;
         end
      end
   end

   always_comb begin
      disp_mux = 16'd0;
      unique case (disp_sel)
         SEL_STEPS:   disp_mux = 16'(step_cnt);
         SEL_HIGH:    disp_mux = {8'd0, high_secs};
         SEL_MAXRATE: disp_mux = {8'd0, max_rate};
         SEL_ELAPSED: disp_mux = {8'd0, elapsed};
         default:     disp_mux = 16'd0;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         DISP_VALUE <= 16'd0;
         SAT        <= 1'b0;
      end else begin
         DISP_VALUE <= disp_mux;
         SAT        <= (step_cnt == STEP_TOP);
      end
   end

   assign GEN_START = run_act;
   assign GEN_MODE  = gen_mode;
   assign DISP_SEL  = disp_sel;

endmodule

// File: tb/tb_pulse_session_ctrl.sv
// Scoreboard bench for pulse_session_ctrl with a 100-cycle second.
module tb_pulse_session_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        START_SW;
   logic        MODE_BTN;
   logic        PULSE_IN;
   logic        GEN_START;
   logic [1:0]  GEN_MODE;
   logic [1:0]  DISP_SEL;
   logic [15:0] DISP_VALUE;
   logic        SAT;

   pulse_session_ctrl #(
      .CYCLES_PER_SEC(100),
      .STEP_MAX      (9999),
      .HIGH_RATE     (32)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .START_SW  (START_SW),
      .MODE_BTN  (MODE_BTN),
      .PULSE_IN  (PULSE_IN),
      .GEN_START (GEN_START),
      .GEN_MODE  (GEN_MODE),
      .DISP_SEL  (DISP_SEL),
      .DISP_VALUE(DISP_VALUE),
      .SAT       (SAT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int exp);
      exp_t e;
      e.tag = tag;
      e.exp = 32'(exp);
      sbq.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      if (sbq.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sbq.pop_front();
         chk(e.tag, obs, e.exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_steps(input int n);
      for (int i = 0; i < n; i++) begin
         PULSE_IN = 1'b1;
         cyc();
         PULSE_IN = 1'b0;
         cyc();
      end
   endtask

   task automatic wait_elapsed(input int target, input int budget);
      int k;
      k = 0;
      while (dut.elapsed != 8'(target) && k < budget) begin
         cyc();
         k++;
      end
      chk("elapsed_reach", 32'(dut.elapsed), 32'(target));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int k;
      RESET    = 1'b1;
      START_SW = 1'b0;
      MODE_BTN = 1'b0;
      PULSE_IN = 1'b0;
      repeat (3) cyc();

      push("rst_gen_start", 0);
      push("rst_gen_mode", 0);
      push("rst_disp_sel", 0);
      push("rst_disp_value", 0);
      push("rst_sat", 0);
      push("rst_steps", 0);
      pop_chk(32'(GEN_START));
      pop_chk(32'(GEN_MODE));
      pop_chk(32'(DISP_SEL));
      pop_chk(32'(DISP_VALUE));
      pop_chk(32'(SAT));
      pop_chk(32'(dut.step_cnt));

      RESET = 1'b0;
      cyc();

      // first second: 40 steps
      START_SW = 1'b1;
      cyc();
      n = 1;
      pulse_steps(40);
      n += 80;
      while (dut.elapsed == 8'd0 && n < 300) begin
         cyc();
         n++;
      end
      push("tick_latency", 101);
      push("s1_elapsed", 1);
      push("s1_high_secs", 1);
      push("s1_max_rate", 40);
      push("s1_steps", 40);
      push("s1_sec_cnt", 0);
      push("s1_gen_start", 1);
      pop_chk(32'(n));
      pop_chk(32'(dut.elapsed));
      pop_chk(32'(dut.high_secs));
      pop_chk(32'(dut.max_rate));
      pop_chk(32'(dut.step_cnt));
      pop_chk(32'(dut.sec_cnt));
      pop_chk(32'(GEN_START));

      // second 2: 49 steps, then a 50th exactly on the tick
      pulse_steps(49);
      k = 0;
      while (dut.tick != 1'b1 && k < 20) begin
         cyc();
         k++;
      end
      chk("tick_seen", 32'(dut.tick), 32'd1);
      PULSE_IN = 1'b1;
      cyc();
      PULSE_IN = 1'b0;
      push("coin_max_rate", 50);
      push("coin_sec_cnt", 0);
      push("coin_high_secs", 2);
      push("coin_elapsed", 2);
      push("coin_disp_sel", 1);
      push("coin_steps", 90);
      pop_chk(32'(dut.max_rate));
      pop_chk(32'(dut.sec_cnt));
      pop_chk(32'(dut.high_secs));
      pop_chk(32'(dut.elapsed));
      pop_chk(32'(DISP_SEL));
      pop_chk(32'(dut.step_cnt));
      cyc();
      push("coin_disp_value", 2);
      pop_chk(32'(DISP_VALUE));

      // display rotation through elapsed = 8
      push("rot_e3", 1);
      push("rot_e4", 2);
      push("rot_e5", 2);
      push("rot_e6", 3);
      push("rot_e7", 3);
      push("rot_e8", 0);
      for (int e = 3; e <= 8; e++) begin
         wait_elapsed(e, 150);
         pop_chk(32'(DISP_SEL));
      end
      push("rot_high_secs", 2);
      push("rot_max_rate", 50);
      pop_chk(32'(dut.high_secs));
      pop_chk(32'(dut.max_rate));
      cyc();
      push("rot_disp_steps", 90);
      pop_chk(32'(DISP_VALUE));

      // mode press while running
      MODE_BTN = 1'b1;
      cyc();
      push("rs_gen_start", 0);
      push("rs_gen_mode", 1);
      push("rs_steps", 0);
      push("rs_elapsed", 0);
      pop_chk(32'(GEN_START));
      pop_chk(32'(GEN_MODE));
      pop_chk(32'(dut.step_cnt));
      pop_chk(32'(dut.elapsed));
      cyc();
      push("rs_gen_start_back", 1);
      pop_chk(32'(GEN_START));
      MODE_BTN = 1'b0;
      cyc();

      // stop, then presses and pulses in IDLE
      pulse_steps(5);
      START_SW = 1'b0;
      cyc();
      push("idle_gen_start", 0);
      pop_chk(32'(GEN_START));
      pulse_steps(3);
      push("idle_mode_a", 2);
      push("idle_mode_b", 3);
      push("idle_mode_wrap", 0);
      push("idle_mode_c", 1);
      for (int p = 0; p < 4; p++) begin
         MODE_BTN = 1'b1;
         cyc();
         MODE_BTN = 1'b0;
         cyc();
         pop_chk(32'(GEN_MODE));
      end
      push("idle_steps_held", 5);
      push("idle_still_idle", 0);
      pop_chk(32'(dut.step_cnt));
      pop_chk(32'(GEN_START));

      // new session clears metrics
      START_SW = 1'b1;
      cyc();
      push("new_steps", 0);
      push("new_gen_start", 1);
      push("new_elapsed", 0);
      pop_chk(32'(dut.step_cnt));
      pop_chk(32'(GEN_START));
      pop_chk(32'(dut.elapsed));

      // saturation
      pulse_steps(9998);
      cyc();
      push("pre_sat_steps", 9998);
      push("pre_sat_flag", 0);
      pop_chk(32'(dut.step_cnt));
      pop_chk(32'(SAT));
      pulse_steps(7);
      cyc();
      push("sat_steps", 9999);
      push("sat_flag", 1);
      push("sat_gen_mode", 1);
      pop_chk(32'(dut.step_cnt));
      pop_chk(32'(SAT));
      pop_chk(32'(GEN_MODE));

      // reset in the middle of a session
      #2;
      RESET = 1'b1;
      #1;
      push("mid_gen_start", 0);
      push("mid_gen_mode", 0);
      push("mid_disp_sel", 0);
      push("mid_disp_value", 0);
      push("mid_sat", 0);
      push("mid_steps", 0);
      pop_chk(32'(GEN_START));
      pop_chk(32'(GEN_MODE));
      pop_chk(32'(DISP_SEL));
      pop_chk(32'(DISP_VALUE));
      pop_chk(32'(SAT));
      pop_chk(32'(dut.step_cnt));
      START_SW = 1'b0;
      cyc();
      cyc();
      RESET = 1'b0;
      cyc();
      pulse_steps(3);
      push("post_rst_steps", 0);
      push("post_rst_idle", 0);
      pop_chk(32'(dut.step_cnt));
      pop_chk(32'(GEN_START));
      START_SW = 1'b1;
      cyc();
      pulse_steps(2);
      push("resume_steps", 2);
      push("resume_run", 1);
      pop_chk(32'(dut.step_cnt));
      pop_chk(32'(GEN_START));

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
